// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: byte/word geometry
// helpers and the bad-address rule used by the top level.
package dmem_pkg;

    localparam int ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    // Number of bytes in one data word.
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Number of byte-offset bits below the word index.
    function automatic int addr_lsb_of(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // An address is bad when it is not word aligned or it points past the array.
    function automatic logic is_bad_addr(input addr_t addr, input int data_width, input int depth);
        int unsigned lsb;
        addr_t       mask;
        addr_t       word;
        lsb  = $clog2(data_width / 8);
        mask = (addr_t'(1) << lsb) - addr_t'(1);
        word = addr >> lsb;
        return ((addr & mask) != '0) || (word >= addr_t'(depth));
    endfunction

endpackage

// File: rtl/dmem_pipe_resp_fifo.sv
// First-word-fall-through response queue. Push and pop on the same edge are
// legal even when full; the head entry is visible whenever o_valid is high.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_valid   = (r_count != '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && o_valid;
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy bookkeeping; cleared by reset to drop queued entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
        end
    end

    // Entry storage; contents are only meaningful when counted as occupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined single-port data memory with byte-enabled writes, credit-based
// read flow control and an in-order, backpressure-tolerant response path.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int BYTES    = bytes_of(DATA_WIDTH);
    localparam int ADDR_LSB = addr_lsb_of(DATA_WIDTH);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CRW      = $clog2(RD_LAT + 1);

    logic                  w_bad;
    logic                  w_acc;
    logic                  w_rd_acc;
    logic                  w_wr_en;
    logic                  w_pop;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH:0]   w_fifo_data;
    logic [CRW-1:0]        r_credits;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [RD_LAT-1:0]     r_vld_p;
    logic [RD_LAT-1:0]     r_err_p;
    logic [DATA_WIDTH-1:0] r_dat_p [RD_LAT];

    assign w_bad     = is_bad_addr(req_addr, DATA_WIDTH, DEPTH);
    assign w_idx     = req_addr[ADDR_LSB +: IDX_W];
    // Credits bound reads in flight plus queued to the FIFO depth, so the
    // FIFO can never overflow. Writes are throttled too, keeping ready uniform.
    assign req_ready = (r_credits != '0);
    assign w_acc     = req_valid && req_ready;
    assign w_rd_acc  = w_acc && !req_we;
    assign w_wr_en   = w_acc && req_we && !w_bad;
    assign w_pop     = rsp_valid && rsp_ready;

    // Read credit counter: one credit per outstanding read, returned on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CRW'(RD_LAT);
        end else if (w_rd_acc && !w_pop) begin
            r_credits <= r_credits - CRW'(1);
        end else if (!w_rd_acc && w_pop) begin
            r_credits <= r_credits + CRW'(1);
        end
    end

    // Byte-enabled write port; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) r_mem[w_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    // Read valid chain: stage 0 is loaded on the accept edge, last stage pushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_rd_acc;
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    // Read data chain: array sampled on the accept edge, bad reads forced to zero.
    always_ff @(posedge clk) begin
        r_dat_p[0] <= w_bad ? '0 : r_mem[w_idx];
        r_err_p[0] <= w_bad;
        for (int i = 1; i < RD_LAT; i++) begin
            r_dat_p[i] <= r_dat_p[i-1];
            r_err_p[i] <= r_err_p[i-1];
        end
    end

    resp_fifo #(
        .DEPTH (RD_LAT),
        .WIDTH (DATA_WIDTH + 1)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld_p[RD_LAT-1]),
        .i_data  ({r_err_p[RD_LAT-1], r_dat_p[RD_LAT-1]}),
        .i_pop   (w_pop),
        .o_valid (rsp_valid),
        .o_data  (w_fifo_data)
    );

    // Outputs read as zero whenever no response is presented (including reset).
    assign rsp_rdata = rsp_valid ? w_fifo_data[DATA_WIDTH-1:0] : '0;
    assign rsp_err   = rsp_valid & w_fifo_data[DATA_WIDTH];

endmodule
